// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter for one shared 8:1 MUX channel; optional grant timeout via MUX_ARB_TIMEOUT_EN
module mux_rr_arbiter #(
  parameter int SEL_WIDTH        = 3,
  parameter int GAP_CYCLES       = 1,
  parameter int MAX_GRANT_CYCLES = 16
) (
  input  logic                      Clock_In,
  input  logic                      Reset_In,
  input  logic [(1<<SEL_WIDTH)-1:0] Request_In,
  output logic [(1<<SEL_WIDTH)-1:0] Grant_Out,
  output logic [SEL_WIDTH-1:0]      Select_Out,
  output logic                      Enable_Out,
  output logic                      Busy_Out,
  output logic                      Timeout_Out
);
  localparam int N = 1 << SEL_WIDTH;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state, state_n;
  logic [N-1:0] grant, grant_n;
  logic [SEL_WIDTH-1:0] sel, sel_n, ptr, ptr_n, win, idx;
  logic [3:0] gap_cnt, gap_n;
  logic found, arb, new_grant, to_hit;
  if (GAP_CYCLES < 0 || GAP_CYCLES > 15 || MAX_GRANT_CYCLES < 1) begin : g_param_check
    $error("mux_rr_arbiter: parameter out of range");
  end
  // Round-robin search starting just after the last winner; the last winner itself has lowest priority
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      idx = ptr + SEL_WIDTH'(i);
      if (Request_In[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // Next-state logic: release or timeout leads to a gap (or immediate re-arbitration when no gap)
  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n = sel;
    ptr_n = ptr;
    gap_n = gap_cnt;
    arb = 1'b0;
    new_grant = 1'b0;
    case (state)
      IDLE: arb = 1'b1;
      GRANT:
        if (!Request_In[sel] || to_hit) begin
          grant_n = '0;
          if (GAP_CYCLES > 0) begin
            state_n = GAP;
            gap_n = 4'(GAP_CYCLES - 1);
          end else arb = 1'b1;
        end
      GAP: if (gap_cnt == '0) arb = 1'b1; else gap_n = gap_cnt - 1'b1;
      default: state_n = IDLE;
    endcase
    if (arb) begin
      state_n = found ? GRANT : IDLE;
      grant_n = found ? N'(1) << win : '0;
      sel_n = found ? win : sel;
      ptr_n = found ? win : ptr;
      new_grant = found;
    end
  end
  // State and output registers; pointer resets so that index 0 is searched first
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state <= IDLE;
      grant <= '0;
      sel <= '0;
      ptr <= '1;
      gap_cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      sel <= sel_n;
      ptr <= ptr_n;
      gap_cnt <= gap_n;
    end
  end
  assign Grant_Out = grant;
  assign Select_Out = sel;
  assign Enable_Out = |grant;
  assign Busy_Out = state != IDLE;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CL = $clog2(MAX_GRANT_CYCLES + 1);
  localparam int CW = CL < 4 ? 4 : (CL > 8 ? 8 : CL);
  logic [CW-1:0] cnt;
  logic timeout;
  assign to_hit = state == GRANT && Request_In[sel] && cnt == CW'(MAX_GRANT_CYCLES - 1);
  // Saturating count of enabled cycles in the current grant; pulse on forced revoke
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= new_grant ? '0 : (state == GRANT && cnt != '1) ? cnt + 1'b1 : cnt;
      timeout <= to_hit;
    end
  end
  assign Timeout_Out = timeout;
`else
  assign to_hit = 1'b0;
  assign Timeout_Out = 1'b0;
`endif
endmodule
